glb_core_strm_router_mc: RTL

GLB_CORE_STRM_ROUTER_MC -- requirements
Module: glb_core_strm_router_mc

---
 rtl/global_buffer_param.sv | 4 +
 rtl/global_buffer_pkg.sv | 11 +
 rtl/glb_strm_pipe.sv | 34 +++
 rtl/glb_core_strm_router_mc.sv | 130 +++++++++++++
 4 files changed

// File: rtl/global_buffer_param.sv
// Global buffer sizing constants shared across the GLB codebase.
package global_buffer_param;
   localparam int TILE_SEL_ADDR_WIDTH = 5;
endpackage

// File: rtl/global_buffer_pkg.sv
// Global buffer stream types and the ingress pipeline depth limits.
package global_buffer_pkg;
   localparam int STRM_PKT_W     = 64;
   localparam int PIPE_DEPTH_MIN = 1;
   localparam int PIPE_DEPTH_MAX = 4;

   typedef struct packed {
      logic                  vld;
      logic [STRM_PKT_W-1:0] pkt;
   } strm_ch_t;
endpackage

// File: rtl/glb_strm_pipe.sv
// Ingress hop pipeline: valid shifts every enabled cycle, data only loads
// behind a valid so idle slots keep the last packet.
module glb_strm_pipe #(
   parameter int PKT_W      = 64,
   parameter int PIPE_DEPTH = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clk_en,
   input  logic             vld_in,
   input  logic [PKT_W-1:0] pkt_in,
   output logic             vld_out,
   output logic [PKT_W-1:0] pkt_out
);
   logic [PIPE_DEPTH-1:0]            vld_p;
   logic [PIPE_DEPTH-1:0][PKT_W-1:0] pkt_p;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         vld_p <= '0;
         pkt_p <= '0;
      end else if (clk_en) begin
         vld_p[0] <= vld_in;
         if (vld_in) pkt_p[0] <= pkt_in;
         for (int i = 1; i < PIPE_DEPTH; i++) begin
            vld_p[i] <= vld_p[i-1];
            if (vld_p[i-1]) pkt_p[i] <= pkt_p[i-1];
         end
      end
   end

   assign vld_out = vld_p[PIPE_DEPTH-1];
   assign pkt_out = pkt_p[PIPE_DEPTH-1];
endmodule

// File: rtl/glb_core_strm_router_mc.sv
// Multi-channel GLB stream router: east/west chain hops, tile turnaround and core port.
// Optional per-channel delivered-packet counters with macro GLB_STRM_PKT_CNT_EN.
module glb_core_strm_router_mc
   import global_buffer_pkg::*;
   import global_buffer_param::*;
#(
   parameter int NUM_CH     = 2,
   parameter int PKT_W      = 64,
   parameter int PIPE_DEPTH = 1,
   parameter int CNT_W      = 16
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           clk_en,
   input  logic [TILE_SEL_ADDR_WIDTH-1:0] glb_tile_id,
   input  logic [NUM_CH*PKT_W-1:0]        pkt_w2e_wsti,
   input  logic [NUM_CH-1:0]              vld_w2e_wsti,
   input  logic [NUM_CH*PKT_W-1:0]        pkt_e2w_esti,
   input  logic [NUM_CH-1:0]              vld_e2w_esti,
   output logic [NUM_CH*PKT_W-1:0]        pkt_e2w_wsto,
   output logic [NUM_CH-1:0]              vld_e2w_wsto,
   output logic [NUM_CH*PKT_W-1:0]        pkt_w2e_esto,
   output logic [NUM_CH-1:0]              vld_w2e_esto,
   input  logic [NUM_CH*PKT_W-1:0]        pkt_sw2sr,
   input  logic [NUM_CH-1:0]              vld_sw2sr,
   output logic [NUM_CH*PKT_W-1:0]        pkt_sr2sw,
   output logic [NUM_CH-1:0]              vld_sr2sw,
   input  logic                           cfg_tile_connected_prev,
   input  logic                           cfg_tile_connected_next,
   input  logic [NUM_CH-1:0]              cfg_ch_en
`ifdef GLB_STRM_PKT_CNT_EN
   ,
   input  logic                           cnt_clr,
   output logic [NUM_CH*CNT_W-1:0]        pkt_cnt
`endif
);
   localparam int DEPTH = (PIPE_DEPTH < PIPE_DEPTH_MIN) ? PIPE_DEPTH_MIN :
                          (PIPE_DEPTH > PIPE_DEPTH_MAX) ? PIPE_DEPTH_MAX : PIPE_DEPTH;

   typedef struct packed {
      logic             vld;
      logic [PKT_W-1:0] pkt;
   } ch_t;

   logic even_tile;
   logic unused_tile_hi;
   assign even_tile      = ~glb_tile_id[0];
   assign unused_tile_hi = ^glb_tile_id[TILE_SEL_ADDR_WIDTH-1:1];

   for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      ch_t eb_pipe, wb_pipe, eb_trn, wb_trn, eb_d1, wb_d1, sw_d1;
      ch_t west_out, east_out, core_out;
      logic vld_sw_in;

      glb_strm_pipe #(.PKT_W(PKT_W), .PIPE_DEPTH(DEPTH)) u_pipe_w2e (
         .clk     (clk),
         .reset   (reset),
         .clk_en  (clk_en),
         .vld_in  (vld_w2e_wsti[c] & cfg_ch_en[c]),
         .pkt_in  (pkt_w2e_wsti[c*PKT_W +: PKT_W]),
         .vld_out (eb_pipe.vld),
         .pkt_out (eb_pipe.pkt)
      );

      glb_strm_pipe #(.PKT_W(PKT_W), .PIPE_DEPTH(DEPTH)) u_pipe_e2w (
         .clk     (clk),
         .reset   (reset),
         .clk_en  (clk_en),
         .vld_in  (vld_e2w_esti[c] & cfg_ch_en[c]),
         .pkt_in  (pkt_e2w_esti[c*PKT_W +: PKT_W]),
         .vld_out (wb_pipe.vld),
         .pkt_out (wb_pipe.pkt)
      );

      assign vld_sw_in = vld_sw2sr[c] & cfg_ch_en[c];

      // turned_d1 / sw2sr_d1 stage
      always_ff @(posedge clk or posedge reset) begin
         if (reset) begin
            eb_d1 <= '0;
            wb_d1 <= '0;
            sw_d1 <= '0;
         end else if (clk_en) begin
            eb_d1.vld <= eb_trn.vld;
            if (eb_trn.vld) eb_d1.pkt <= eb_trn.pkt;
            wb_d1.vld <= wb_trn.vld;
            if (wb_trn.vld) wb_d1.pkt <= wb_trn.pkt;
            sw_d1.vld <= vld_sw_in;
            if (vld_sw_in) sw_d1.pkt <= pkt_sw2sr[c*PKT_W +: PKT_W];
         end
      end

      // An unlinked side folds the opposite-going output back into the tile.
      always_comb begin
         west_out = even_tile ? wb_d1 : sw_d1;
         east_out = even_tile ? sw_d1 : eb_d1;
         eb_trn   = cfg_tile_connected_prev ? eb_pipe : west_out;
         wb_trn   = cfg_tile_connected_next ? wb_pipe : east_out;
         core_out = even_tile ? eb_trn : wb_trn;
      end

      assign vld_e2w_wsto[c]              = west_out.vld & cfg_ch_en[c];
      assign pkt_e2w_wsto[c*PKT_W +: PKT_W] = west_out.pkt;
      assign vld_w2e_esto[c]              = east_out.vld & cfg_ch_en[c];
      assign pkt_w2e_esto[c*PKT_W +: PKT_W] = east_out.pkt;
      assign vld_sr2sw[c]                 = core_out.vld & cfg_ch_en[c];
      assign pkt_sr2sw[c*PKT_W +: PKT_W]    = core_out.pkt;
   end

`ifdef GLB_STRM_PKT_CNT_EN
   logic [NUM_CH-1:0][CNT_W-1:0] cnt;

   // Saturating counters; clear wins over a same-cycle delivery.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt <= '0;
      end else if (clk_en) begin
         for (int c = 0; c < NUM_CH; c++) begin
            if (cnt_clr) cnt[c] <= '0;
            else if (vld_sr2sw[c] && (cnt[c] != {CNT_W{1'b1}})) cnt[c] <= cnt[c] + CNT_W'(1);
         end
      end
   end

   assign pkt_cnt = cnt;
`else
   logic [CNT_W-1:0] unused_cnt_w;
   assign unused_cnt_w = '0;
`endif
endmodule
